// File: rtl/memory_matrix_round_ctrl_pkg.sv
// Shared state encoding and default sizing for the Memory Matrix round controller.
package memory_matrix_pkg;

  localparam int BOARD_W_DEF = 8;
  localparam int IDX_W_DEF   = 3;
  localparam int LIVES_DEF   = 3;
  localparam int STATE_W     = 3;
  localparam int TIMER_W     = 32;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_LATCH = 3'd2,
    S_SHOW  = 3'd3,
    S_INPUT = 3'd4,
    S_WIN   = 3'd5,
    S_MISS  = 3'd6,
    S_OVER  = 3'd7
  } state_t;

endpackage

// File: rtl/memory_matrix_round_ctrl_if.sv
// Key/switch inputs, datapath board and LED/score outputs of the round controller.
interface memory_matrix_round_ctrl_if
  import memory_matrix_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int SCORE_W = 8
);

  logic               start;
  logic [BOARD_W-1:0] board_in;
  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic               ld_board;
  logic [BOARD_W-1:0] led_board;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;
  logic               round_won;
  logic               life_lost;
  logic               game_over;

  modport master (
    input  start, board_in, sel_valid, sel_idx,
    output ld_board, led_board, score, lives, round_won, life_lost, game_over
  );

  modport slave (
    output start, board_in, sel_valid, sel_idx,
    input  ld_board, led_board, score, lives, round_won, life_lost, game_over
  );

endinterface

// File: rtl/memory_matrix_round_ctrl_phase_timer.sv
// Shared phase counter for the show and input windows; clear wins over enable.
module phase_timer
  import memory_matrix_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] terminal_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == terminal_i);

endmodule

// File: rtl/memory_matrix_round_ctrl.sv
// Round sequencer: fetch a board, show it, score tile picks, track score and lives.
module memory_matrix_round_ctrl
  import memory_matrix_pkg::*;
#(
  parameter int BOARD_W      = BOARD_W_DEF,
  parameter int IDX_W        = IDX_W_DEF,
  parameter int SHOW_CYCLES  = 50000000,
  parameter int INPUT_CYCLES = 500000000,
  parameter int LIVES        = LIVES_DEF,
  parameter int SCORE_W      = 8
) (
  input logic                       clk,
  input logic                       reset,
  memory_matrix_round_ctrl_if.master bus
);

  state_t               state_q, state_d;
  logic [BOARD_W-1:0]   board_q, board_d;
  logic [BOARD_W-1:0]   found_q, found_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [2:0]           lives_q, lives_d;

  logic                 timerClr, timerEn, timerTc;
  logic [TIMER_W-1:0]   terminal;
  logic                 pickInRange, pickOnBoard, pickNew;
  logic [BOARD_W-1:0]   pickMask, foundNext;
  logic [BOARD_W-1:0]   ledBoard;

  // An index past the last tile can only exist when the index field is wider than needed.
  if ((1 << IDX_W) > BOARD_W) begin : g_range
    assign pickInRange = int'(bus.sel_idx) < BOARD_W;
  end else begin : g_full
    assign pickInRange = 1'b1;
  end

  assign pickMask    = pickInRange ? (BOARD_W'(1) << bus.sel_idx) : '0;
  assign pickOnBoard = |(pickMask & board_q);
  assign pickNew     = |(pickMask & board_q & ~found_q);
  assign foundNext   = found_q | pickMask;

  assign terminal = (state_q == S_SHOW) ? TIMER_W'(SHOW_CYCLES - 1)
                                        : TIMER_W'(INPUT_CYCLES - 1);

  phase_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (timerClr),
    .en_i       (timerEn),
    .terminal_i (terminal),
    .tc_o       (timerTc)
  );

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    found_d  = found_q;
    score_d  = score_q;
    lives_d  = lives_q;
    timerClr = 1'b0;
    timerEn  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_GEN;
          score_d = '0;
          lives_d = 3'(LIVES);
        end
      end
      S_GEN: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        board_d  = bus.board_in;
        found_d  = '0;
        timerClr = 1'b1;
        state_d  = (bus.board_in == '0) ? S_GEN : S_SHOW;
      end
      S_SHOW: begin
        timerEn = 1'b1;
        if (timerTc) begin
          timerClr = 1'b1;
          state_d  = S_INPUT;
        end
      end
      S_INPUT: begin
        timerEn = 1'b1;
        // A pick on the terminal cycle overrides the timeout; if it does not end the round the window restarts.
        if (bus.sel_valid) begin
          if (!pickOnBoard) begin
            state_d = S_MISS;
          end else begin
            if (pickNew) begin
              found_d = foundNext;
            end
            if (foundNext == board_q) begin
              state_d = S_WIN;
            end else if (timerTc) begin
              timerClr = 1'b1;
            end
          end
        end else if (timerTc) begin
          state_d = S_MISS;
        end
      end
      S_WIN: begin
        if (score_q != '1) begin
          score_d = score_q + SCORE_W'(1);
        end
        state_d = S_GEN;
      end
      S_MISS: begin
        lives_d = lives_q - 3'd1;
        state_d = (lives_q == 3'd1) ? S_OVER : S_GEN;
      end
      S_OVER: begin
        if (bus.start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      board_q <= '0;
      found_q <= '0;
      score_q <= '0;
      lives_q <= 3'(LIVES);
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      found_q <= found_d;
      score_q <= score_d;
      lives_q <= lives_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    ledBoard = '0;
    unique case (state_q)
      S_SHOW:  ledBoard = board_q;
      S_INPUT: ledBoard = found_q;
      S_OVER:  ledBoard = board_q;
      default: ledBoard = '0;
    endcase
  end

  assign bus.ld_board  = (state_q == S_GEN);
  assign bus.led_board = ledBoard;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;
  assign bus.round_won = (state_q == S_WIN);
  assign bus.life_lost = (state_q == S_MISS);
  assign bus.game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_memory_matrix_round_ctrl.sv
// Self-checking bench: a game-rules model is compared against the controller every cycle.
module tb_memory_matrix_round_ctrl;

  localparam int BW     = 8;
  localparam int SHOW   = 4;
  localparam int INWIN  = 20;
  localparam int NLIVES = 3;

  typedef enum {M_IDLE, M_GEN, M_LATCH, M_SHOW, M_INPUT, M_WIN, M_MISS, M_OVER} mphase_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic checkEn = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   ldPulses = 0;
  int   ldBefore;
  logic [7:0] boardQ[$];

  mphase_t    mPh;
  logic [7:0] mBoard, mFound;
  int         mScore, mLives, mLeft;

  memory_matrix_round_ctrl_if #(.BOARD_W(BW), .IDX_W(3), .SCORE_W(8)) busIf ();

  memory_matrix_round_ctrl #(
    .BOARD_W(BW), .IDX_W(3), .SHOW_CYCLES(SHOW), .INPUT_CYCLES(INWIN),
    .LIVES(NLIVES), .SCORE_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: a new board appears whenever the controller strobes ld_board.
  always @(negedge clk) begin
    if (busIf.ld_board) begin
      ldPulses++;
      if (boardQ.size() > 0) busIf.board_in = boardQ.pop_front();
      else busIf.board_in = 8'hA5;
    end
  end

  // Game-rules model: phases with countdowns, tiles tracked as a set.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mPh = M_IDLE; mBoard = 0; mFound = 0; mScore = 0; mLives = NLIVES; mLeft = 0;
    end else begin
      case (mPh)
        M_IDLE: if (busIf.start) begin mPh = M_GEN; mScore = 0; mLives = NLIVES; end
        M_GEN: mPh = M_LATCH;
        M_LATCH: begin
          mBoard = busIf.board_in; mFound = 0;
          if (mBoard == 0) mPh = M_GEN;
          else begin mPh = M_SHOW; mLeft = SHOW; end
        end
        M_SHOW: begin
          mLeft--;
          if (mLeft == 0) begin mPh = M_INPUT; mLeft = INWIN; end
        end
        M_INPUT: begin
          mLeft--;
          if (busIf.sel_valid) begin
            if (int'(busIf.sel_idx) < BW && mBoard[busIf.sel_idx]) begin
              bit allFound;
              mFound[busIf.sel_idx] = 1'b1;
              allFound = 1'b1;
              for (int i = 0; i < BW; i++) if (mBoard[i] && !mFound[i]) allFound = 1'b0;
              if (allFound) mPh = M_WIN;
              else if (mLeft == 0) mLeft = INWIN;
            end else begin
              mPh = M_MISS;
            end
          end else if (mLeft == 0) begin
            mPh = M_MISS;
          end
        end
        M_WIN: begin
          if (mScore < 255) mScore++;
          mPh = M_GEN;
        end
        M_MISS: begin
          mPh = (mLives == 1) ? M_OVER : M_GEN;
          mLives--;
        end
        M_OVER: if (busIf.start) mPh = M_IDLE;
        default: mPh = M_IDLE;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      logic [7:0] expLed;
      expLed = (mPh == M_SHOW || mPh == M_OVER) ? mBoard : (mPh == M_INPUT ? mFound : 8'h00);
      checkOutput("model ld_board", 32'(busIf.ld_board), 32'(mPh == M_GEN));
      checkOutput("model led_board", 32'(busIf.led_board), 32'(expLed));
      checkOutput("model score", 32'(busIf.score), 32'(mScore));
      checkOutput("model lives", 32'(busIf.lives), 32'(mLives));
      checkOutput("model round_won", 32'(busIf.round_won), 32'(mPh == M_WIN));
      checkOutput("model life_lost", 32'(busIf.life_lost), 32'(mPh == M_MISS));
      checkOutput("model game_over", 32'(busIf.game_over), 32'(mPh == M_OVER));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic sv, input logic [2:0] idx);
    busIf.start = st;
    busIf.sel_valid = sv;
    busIf.sel_idx = idx;
    tick();
    busIf.start = 1'b0;
    busIf.sel_valid = 1'b0;
  endtask

  task automatic waitModel(input mphase_t target, input int maxCycles, input string name);
    for (int i = 0; i < maxCycles && mPh != target; i++) tick();
    if (mPh != target) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL wait %s: phase %0d, expected %0d", name, mPh, target);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    busIf.start = 1'b0;
    busIf.sel_valid = 1'b0;
    busIf.sel_idx = 3'd0;
    busIf.board_in = 8'hFF;
    boardQ = '{8'hA5, 8'hA5, 8'h0F, 8'h81, 8'h00, 8'h3C, 8'h11, 8'h22, 8'hA5};
    #3 reset = 1'b1;
    #20;
    @(posedge clk);
    #1 reset = 1'b0;
    checkEn = 1'b1;
    checkOutput("reset lives", 32'(busIf.lives), 32'd3);
    checkOutput("reset score", 32'(busIf.score), 32'd0);
    checkOutput("reset led", 32'(busIf.led_board), 32'd0);

    // Round 1: show A5 for four cycles, stray pick during show, then win.
    applyStimulus(1'b1, 1'b0, 3'd0);
    checkOutput("gen ld_board", 32'(busIf.ld_board), 32'd1);
    waitModel(M_SHOW, 10, "show1");
    checkOutput("show led A5", 32'(busIf.led_board), 32'hA5);
    applyStimulus(1'b0, 1'b1, 3'd0);
    waitModel(M_INPUT, 10, "input1");
    checkOutput("input led empty", 32'(busIf.led_board), 32'h00);
    applyStimulus(1'b0, 1'b1, 3'd0);
    applyStimulus(1'b0, 1'b1, 3'd2);
    checkOutput("partial led", 32'(busIf.led_board), 32'h05);
    applyStimulus(1'b0, 1'b1, 3'd5);
    applyStimulus(1'b0, 1'b1, 3'd7);
    checkOutput("round_won pulse", 32'(busIf.round_won), 32'd1);
    tick();
    checkOutput("score after win", 32'(busIf.score), 32'd1);
    checkOutput("regen ld_board", 32'(busIf.ld_board), 32'd1);

    // Round 2: repeat pick is free, wrong pick costs a life.
    waitModel(M_INPUT, 20, "input2");
    applyStimulus(1'b0, 1'b1, 3'd0);
    applyStimulus(1'b0, 1'b1, 3'd0);
    checkOutput("repeat no penalty", 32'(busIf.life_lost), 32'd0);
    applyStimulus(1'b0, 1'b1, 3'd1);
    checkOutput("life_lost pulse", 32'(busIf.life_lost), 32'd1);
    tick();
    checkOutput("lives after miss", 32'(busIf.lives), 32'd2);
    checkOutput("miss regen ld", 32'(busIf.ld_board), 32'd1);

    // Two timeouts exhaust the remaining lives.
    waitModel(M_OVER, 200, "over1");
    checkOutput("over flag", 32'(busIf.game_over), 32'd1);
    checkOutput("over reveal", 32'(busIf.led_board), 32'h81);
    checkOutput("over lives", 32'(busIf.lives), 32'd0);
    checkOutput("over score held", 32'(busIf.score), 32'd1);

    // New game: empty board is regenerated, then three timeouts.
    applyStimulus(1'b1, 1'b0, 3'd0);
    checkOutput("idle no over", 32'(busIf.game_over), 32'd0);
    ldBefore = ldPulses;
    applyStimulus(1'b1, 1'b0, 3'd0);
    checkOutput("restart lives", 32'(busIf.lives), 32'd3);
    checkOutput("restart score", 32'(busIf.score), 32'd0);
    waitModel(M_SHOW, 20, "show3");
    checkOutput("empty regen pulses", 32'(ldPulses - ldBefore), 32'd2);
    checkOutput("show led 3C", 32'(busIf.led_board), 32'h3C);
    waitModel(M_OVER, 300, "over2");
    checkOutput("over2 reveal", 32'(busIf.led_board), 32'h22);

    // Reset mid-show returns everything immediately.
    applyStimulus(1'b1, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b0, 3'd0);
    waitModel(M_SHOW, 20, "show4");
    tick();
    reset = 1'b1;
    #1;
    checkOutput("async reset led", 32'(busIf.led_board), 32'd0);
    checkOutput("async reset lives", 32'(busIf.lives), 32'd3);
    checkOutput("async reset ld", 32'(busIf.ld_board), 32'd0);
    checkOutput("async reset score", 32'(busIf.score), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
